mul_norm_pipe: RTL and testbench

Two-stage pipelined normalisation stage for the multiplier datapath. It takes the raw 2·(MANT_W+1)-bit product, the anticipated (uncorrected) leading-zero count and the one-position correction mask. It corrects the count, left-normalises the product and adjusts the biased exponent. A valid/ready handshake with full backpressure sits on both sides. It replaces the purely combinational count-correction step between the product array and rounding.

---
 rtl/mul_pkg.sv | 39 +++
 rtl/mul_lzc_fix.sv | 38 +++
 rtl/mul_norm_pipe.sv | 162 ++++++++++++++++
 tb/tb_mul_norm_pipe.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the multiplier datapath.
//   - calc_pw / calc_zc_w / calc_ew : derive product, zero-count and signed
//     working-exponent widths from the field widths.
//   - MUL_* localparams             : default field widths of the datapath.
//   - norm_beat_t                   : beat carried from the S1 compute logic
//                                     into the S2 register of mul_norm_pipe
//                                     (top mantissa bits, corrected count,
//                                     adjusted exponent). Its field widths
//                                     follow the MUL_* defaults.
// -----------------------------------------------------------------------------
package mul_pkg;

    function automatic int calc_pw(input int mant_w);
        return 2 * mant_w + 2;
    endfunction

    function automatic int calc_zc_w(input int mant_w);
        return $clog2(mant_w + 1);
    endfunction

    function automatic int calc_ew(input int expo_w);
        return expo_w + 2;
    endfunction

    localparam int MUL_EXPO_W = 8;
    localparam int MUL_MANT_W = 23;
    localparam int MUL_PW     = calc_pw(MUL_MANT_W);
    localparam int MUL_ZC_W   = calc_zc_w(MUL_MANT_W);
    localparam int MUL_EW     = calc_ew(MUL_EXPO_W);

    typedef struct packed {
        logic [MUL_MANT_W+1:0] mant;
        logic [MUL_ZC_W-1:0]   zero_c;
        logic [MUL_EW-1:0]     expo;
    } norm_beat_t;

endpackage

// File: rtl/mul_lzc_fix.sv
// -----------------------------------------------------------------------------
// mul_lzc_fix
// Corrects the anticipated leading-zero count. The anticipator can overshoot
// by exactly one position; the mask marks the bit that is set when it did.
//   mant    in  PW        raw product
//   mask    in  MANT_W+1  correction mask, aligned to mant[PW-1:MANT_W+1]
//   zero_uc in  ZC_W      anticipated (uncorrected) leading-zero count
//   zero_c  out ZC_W      corrected leading-zero count (combinational)
// -----------------------------------------------------------------------------
module mul_lzc_fix
    import mul_pkg::*;
#(
    parameter int MANT_W = MUL_MANT_W,
    parameter int PW     = calc_pw(MANT_W),
    parameter int ZC_W   = calc_zc_w(MANT_W)
) (
    input  logic [PW-1:0]   mant,
    input  logic [MANT_W:0] mask,
    input  logic [ZC_W-1:0] zero_uc,
    output logic [ZC_W-1:0] zero_c
);

    logic revise_s;

    // Revise the count down by one when the masked product bit is set; a zero
    // count cannot be revised further, so it stays at zero instead of wrapping.
    always_comb begin
        revise_s = |(mant & {mask, {(MANT_W+1){1'b0}}});
        if (!revise_s) begin
            zero_c = zero_uc;
        end else if (zero_uc == {ZC_W{1'b0}}) begin
            zero_c = {ZC_W{1'b0}};
        end else begin
            zero_c = zero_uc - {{(ZC_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/mul_norm_pipe.sv
// -----------------------------------------------------------------------------
// mul_norm_pipe
// Two-stage normalisation stage for the multiplier datapath: corrects the
// anticipated leading-zero count, left-normalises the product and adjusts the
// biased exponent. Valid/ready handshake with full backpressure on both sides.
//
// Optional feature macro: MUL_NORM_STICKY_EN (adds out_sticky, the OR of the
// product bits dropped below the guard position).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        input handshake (in_ready is combinational on
//                              out_ready, nothing else)
//   in_mant, in_mask           raw product and one-position correction mask
//   in_zero_uc, in_expo        anticipated zero count, signed exponent
//   out_valid / out_ready      output handshake
//   out_mant                   hidden + MANT_W + guard bits after normalising
//   out_zero_c, out_expo       corrected zero count, in_expo - out_zero_c
//   out_sticky                 sticky bit (macro only)
// -----------------------------------------------------------------------------
module mul_norm_pipe
    import mul_pkg::*;
#(
    parameter int EXPO_W = MUL_EXPO_W,
    parameter int MANT_W = MUL_MANT_W,
    parameter int PW     = calc_pw(MANT_W),
    parameter int ZC_W   = calc_zc_w(MANT_W),
    parameter int EW     = calc_ew(EXPO_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PW-1:0]     in_mant,
    input  logic [MANT_W:0]   in_mask,
    input  logic [ZC_W-1:0]   in_zero_uc,
    input  logic [EW-1:0]     in_expo,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W+1:0] out_mant,
    output logic [ZC_W-1:0]   out_zero_c,
    output logic [EW-1:0]     out_expo
`ifdef MUL_NORM_STICKY_EN
    ,
    output logic              out_sticky
`endif
);

    localparam int OW    = MANT_W + 2;   // kept product bits
    localparam int LOW_W = PW - OW;      // bits dropped below the guard bit

    // Handshake / occupancy
    logic s1_adv_s;
    logic s2_adv_s;
    logic s1_valid_r;
    logic s2_valid_r;

    // Stage 1 captured operands
    logic [PW-1:0]   s1_mant_r;
    logic [MANT_W:0] s1_mask_r;
    logic [ZC_W-1:0] s1_zero_uc_r;
    logic [EW-1:0]   s1_expo_r;

    // Stage 1 compute
    logic [ZC_W-1:0] zero_c_s;
    logic [OW-1:0]   shift_top_s;
    logic [EW-1:0]   expo_s;
    norm_beat_t      s2_beat_s;

    // Stage 2 result
    norm_beat_t      s2_beat_r;

`ifdef MUL_NORM_STICKY_EN
    logic [LOW_W-1:0] shift_low_s;
    logic             sticky_s;
    logic             s2_sticky_r;
`endif

    // A stage advances when it is empty or the stage after it drains this cycle.
    always_comb begin
        s2_adv_s = !s2_valid_r || out_ready;
        s1_adv_s = !s1_valid_r || s2_adv_s;
    end

    mul_lzc_fix #(
        .MANT_W (MANT_W),
        .PW     (PW),
        .ZC_W   (ZC_W)
    ) u_lzc_fix (
        .mant    (s1_mant_r),
        .mask    (s1_mask_r),
        .zero_uc (s1_zero_uc_r),
        .zero_c  (zero_c_s)
    );

    // Normalising shift, exponent adjust and packing of the beat for stage 2.
    always_comb begin
        shift_top_s = OW'((s1_mant_r << zero_c_s) >> LOW_W);
        expo_s      = s1_expo_r - {{(EW-ZC_W){1'b0}}, zero_c_s};
        s2_beat_s   = '{mant: shift_top_s, zero_c: zero_c_s, expo: expo_s};
`ifdef MUL_NORM_STICKY_EN
        shift_low_s = LOW_W'(s1_mant_r << zero_c_s);
        sticky_s    = |shift_low_s;
`endif
    end

    // Stage 1: capture the operands of each accepted input beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r   <= 1'b0;
            s1_mant_r    <= {PW{1'b0}};
            s1_mask_r    <= {(MANT_W+1){1'b0}};
            s1_zero_uc_r <= {ZC_W{1'b0}};
            s1_expo_r    <= {EW{1'b0}};
        end else begin
            if (s1_adv_s) begin
                s1_valid_r <= in_valid;
            end
            if (s1_adv_s && in_valid) begin
                s1_mant_r    <= in_mant;
                s1_mask_r    <= in_mask;
                s1_zero_uc_r <= in_zero_uc;
                s1_expo_r    <= in_expo;
            end
        end
    end

    // Stage 2: register the normalised result; outputs come straight from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_beat_r  <= '0;
        end else begin
            if (s2_adv_s) begin
                s2_valid_r <= s1_valid_r;
            end
            if (s2_adv_s && s1_valid_r) begin
                s2_beat_r <= s2_beat_s;
            end
        end
    end

`ifdef MUL_NORM_STICKY_EN
    // Stage 2 sticky bit, advancing together with the rest of the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sticky_r <= 1'b0;
        end else if (s2_adv_s && s1_valid_r) begin
            s2_sticky_r <= sticky_s;
        end
    end

    assign out_sticky = s2_sticky_r;
`endif

    assign in_ready   = s1_adv_s;
    assign out_valid  = s2_valid_r;
    assign out_mant   = s2_beat_r.mant;
    assign out_zero_c = s2_beat_r.zero_c;
    assign out_expo   = s2_beat_r.expo;

endmodule

// File: tb/tb_mul_norm_pipe.sv
// -----------------------------------------------------------------------------
// tb_mul_norm_pipe
// Self-checking bench for mul_norm_pipe (MANT_W=23, EXPO_W=8). Inputs are
// driven 1 time unit after the rising edge, outputs sampled on the falling
// edge. Expected results come from ref_norm(), which applies the arithmetic
// rules directly (count correction, shift, exponent subtract, sticky OR).
// Build with MUL_NORM_STICKY_EN to exercise out_sticky.
// -----------------------------------------------------------------------------
module tb_mul_norm_pipe;

    localparam int MANT_W = 23;
    localparam int EXPO_W = 8;
    localparam int PW     = 48;
    localparam int ZC_W   = 5;
    localparam int EW     = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [PW-1:0]     in_mant;
    logic [MANT_W:0]   in_mask;
    logic [ZC_W-1:0]   in_zero_uc;
    logic [EW-1:0]     in_expo;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W+1:0] out_mant;
    logic [ZC_W-1:0]   out_zero_c;
    logic [EW-1:0]     out_expo;
`ifdef MUL_NORM_STICKY_EN
    logic              out_sticky;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // expected beat layout: [40:16] mant, [15:11] zero_c, [10:1] expo, [0] sticky
    logic [40:0] exp_q[$];

    always #5 clk = ~clk;

    mul_norm_pipe #(.EXPO_W(EXPO_W), .MANT_W(MANT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mant    (in_mant),
        .in_mask    (in_mask),
        .in_zero_uc (in_zero_uc),
        .in_expo    (in_expo),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_zero_c (out_zero_c),
        .out_expo   (out_expo)
`ifdef MUL_NORM_STICKY_EN
        ,
        .out_sticky (out_sticky)
`endif
    );

    wire [39:0] obs_w = {out_mant, out_zero_c, out_expo};

    function automatic logic [40:0] ref_norm(input logic [47:0] m, input logic [23:0] k,
                                             input logic [4:0] zu, input logic [9:0] e);
        int          zc;
        logic [47:0] sh;
        logic [9:0]  eo;
        zc = int'(zu);
        if ((m[47:24] & k) != 24'h0) zc = (zu == 5'd0) ? 0 : int'(zu) - 1;
        sh = m << zc;
        eo = e - 10'(zc);
        return {sh[47:23], 5'(zc), eo, (sh[22:0] != 23'h0)};
    endfunction

    task automatic rand_beat();
        in_mant    = {$urandom(), $urandom()};
        case ($urandom_range(0, 2))
            0:       in_mask = 24'h0;
            1:       in_mask = 24'h1 << $urandom_range(0, 23);
            default: in_mask = 24'($urandom());
        endcase
        in_zero_uc = 5'($urandom_range(0, 31));
        in_expo    = 10'($urandom());
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_mant = 48'h0; in_mask = 24'h0; in_zero_uc = 5'd0; in_expo = 10'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || obs_w !== 40'h0) begin
            n_err++; $display("FAIL reset_outputs: valid=%b data=%h required 0/0", out_valid, obs_w);
        end
`ifdef MUL_NORM_STICKY_EN
        n_cmp++;
        if (out_sticky !== 1'b0) begin n_err++; $display("FAIL reset_sticky: got %b required 0", out_sticky); end
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [47:0] m_t[3]  = '{48'h1000_0000_0000, 48'h0800_0000_0000, 48'h8000_0000_0000};
        logic [23:0] k_t[3]  = '{24'h10_0000, 24'h10_0000, 24'h80_0000};
        logic [4:0]  z_t[3]  = '{5'd3, 5'd4, 5'd0};
        logic [9:0]  e_t[3]  = '{10'd130, 10'd130, 10'd100};
        logic [39:0] x_t[3]  = '{{25'h080_0000, 5'd2, 10'd128},
                                 {25'h100_0000, 5'd4, 10'd126},
                                 {25'h100_0000, 5'd0, 10'd100}};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mant = m_t[i]; in_mask = k_t[i]; in_zero_uc = z_t[i]; in_expo = e_t[i];
            @(posedge clk); #1 in_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL directed%0d_latency1: out_valid=%b required 0", i, out_valid); end
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || obs_w !== x_t[i]) begin
                n_err++; $display("FAIL directed%0d: valid=%b got %h required %h", i, out_valid, obs_w, x_t[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [40:0] e;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 10);
            rand_beat();
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready c%0d: got %b required 1", c, in_ready); end
            n_cmp++;
            if (out_valid !== (c >= 2 && c < 12)) begin
                n_err++; $display("FAIL b2b_valid c%0d: got %b required %b", c, out_valid, (c >= 2 && c < 12));
            end
            if (out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs_w !== e[40:1]) begin n_err++; $display("FAIL b2b_data c%0d: got %h required %h", c, obs_w, e[40:1]); end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_norm(in_mant, in_mask, in_zero_uc, in_expo));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_leftover: %0d beats required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int          accepted = 0;
        int          outs     = 0;
        logic [40:0] e;
        out_ready = 1'b0;
        exp_q.delete();
        rand_beat();
        for (int c = 0; c < 17; c++) begin
            if (c == 5) begin
                n_cmp++;
                if (accepted != 2 || in_ready !== 1'b0) begin
                    n_err++; $display("FAIL bp_stall: accepted=%0d in_ready=%b required 2/0", accepted, in_ready);
                end
                out_ready = 1'b1;
            end
            in_valid = (accepted < 3);
            @(negedge clk);
            if (out_valid && out_ready) begin
                outs++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL bp_dup: unexpected beat %h required none", obs_w);
                end else begin
                    e = exp_q.pop_front();
                    if (obs_w !== e[40:1]) begin n_err++; $display("FAIL bp_order: got %h required %h", obs_w, e[40:1]); end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_norm(in_mant, in_mask, in_zero_uc, in_expo));
                accepted++;
                @(posedge clk); #1 rand_beat();
            end else begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (outs != 3 || exp_q.size() != 0) begin
            n_err++; $display("FAIL bp_drain: outputs=%0d pending=%0d required 3/0", outs, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [40:0] e;
        exp_q.delete();
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rand_extra c%0d: beat %h required none", c, obs_w);
                end else begin
                    e = exp_q.pop_front();
                    if (obs_w !== e[40:1]) begin n_err++; $display("FAIL rand_data c%0d: got %h required %h", c, obs_w, e[40:1]); end
`ifdef MUL_NORM_STICKY_EN
                    n_cmp++;
                    if (out_sticky !== e[0]) begin n_err++; $display("FAIL rand_sticky c%0d: got %b required %b", c, out_sticky, e[0]); end
`endif
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_norm(in_mant, in_mask, in_zero_uc, in_expo));
                @(posedge clk); #1;
                in_valid = ($urandom_range(0, 2) != 0);
                rand_beat();
            end else begin
                @(posedge clk); #1;
                if (!in_valid) begin in_valid = ($urandom_range(0, 2) != 0); rand_beat(); end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs_w !== e[40:1]) begin n_err++; $display("FAIL rand_drain: got %h required %h", obs_w, e[40:1]); end
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_lost: %0d beats never emerged, required 0", exp_q.size()); end
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        logic [40:0] e;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; rand_beat();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL mid_full: out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || obs_w !== 40'h0) begin
            n_err++; $display("FAIL mid_reset: valid=%b data=%h required 0/0", out_valid, obs_w);
        end
        @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b1; rand_beat();
        e = ref_norm(in_mant, in_mask, in_zero_uc, in_expo);
        @(posedge clk); #1 in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale: out_valid=%b required 0", out_valid); end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || obs_w !== e[40:1]) begin
            n_err++; $display("FAIL mid_next: valid=%b got %h required %h", out_valid, obs_w, e[40:1]);
        end
        @(posedge clk); #1;
    endtask

`ifdef MUL_NORM_STICKY_EN
    task automatic test_sticky();
        logic [47:0] m_t[2] = '{48'h8000_0000_0001, 48'h8000_0000_0000};
        logic        s_t[2] = '{1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_mant = m_t[i]; in_mask = 24'h0; in_zero_uc = 5'd0; in_expo = 10'd5;
            @(posedge clk); #1 in_valid = 1'b0;
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_sticky !== s_t[i]) begin
                n_err++; $display("FAIL sticky%0d: valid=%b sticky=%b required 1/%b", i, out_valid, out_sticky, s_t[i]);
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
`ifdef MUL_NORM_STICKY_EN
        test_sticky();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
